// File: rtl/packet_stream_checker_pkg.sv
// Shared framing constants, FSM encoding and pointer sizing for the packet stream checker.
package packet_stream_checker_pkg;

    localparam logic [31:0] HEADER_VALUE = 32'hAAAA_AAAA;
    localparam logic [31:0] FOOTER_VALUE = 32'h5555_5555;
    localparam logic [31:0] TLAST_VALUE  = 32'hBBBB_BBBB;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_TSTAMP      = 3'd1,
        ST_PAYLOAD     = 3'd2,
        ST_POST_FOOTER = 3'd3,
        ST_DROP        = 3'd4
    } state_t;

    // One extra bit beyond the address so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/frame_commit_fifo.sv
// Circular frame buffer with speculative write, commit and read pointers and a
// registered AXIS read port that only ever exposes committed words.
module frame_commit_fifo
    import packet_stream_checker_pkg::*;
#(
    parameter int DEPTH = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        wr_last,
    input  logic        commit,
    input  logic        rollback,
    output logic        full,
    output logic        full_cm,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [32:0]   mem [DEPTH];
    logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, cm_vis_q, rd_q, rd_d, base;
    logic [31:0]   tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d, tlast_q, tlast_d, load;

    assign full     = (wr_q - rd_q) == PW'(DEPTH);
    assign full_cm  = (cm_q - rd_q) == PW'(DEPTH);
    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;

    // A rollback rebases the write at the commit pointer in the same cycle, so a
    // header arriving mid-frame lands where the discarded frame started.
    always_comb begin
        base     = rollback ? cm_q : wr_q;
        wr_d     = wr_en ? base + ONE : base;
        cm_d     = (wr_en && commit) ? base + ONE : cm_q;
        load     = (cm_vis_q != rd_q) && (!tvalid_q || m_tready);
        rd_d     = load ? rd_q + ONE : rd_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q && !m_tready;
        if (load) begin
            {tlast_d, tdata_d} = mem[rd_q[AW-1:0]];
            tvalid_d = 1'b1;
        end
    end

    // cm_vis_q delays commit visibility by one cycle so the footer's RAM write
    // has settled before the read side may fetch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= '0;
            cm_q     <= '0;
            cm_vis_q <= '0;
            rd_q     <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            cm_q     <= cm_d;
            cm_vis_q <= cm_q;
            rd_q     <= rd_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[base[AW-1:0]] <= {wr_last, wr_data};
    end

endmodule

// File: rtl/packet_stream_checker.sv
// Frame parser FSM and saturating status counters in front of a commit/rollback frame buffer.
module packet_stream_checker
    import packet_stream_checker_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2048,
    parameter int MAX_PAYLOAD = 1024
) (
    input  logic        master_clock,
    input  logic        resetn,
    input  logic [31:0] s_data_tdata,
    input  logic        s_data_tvalid,
    input  logic        s_data_tlast,
    output logic        s_data_tready,
    output logic [31:0] m_data_tdata,
    output logic        m_data_tvalid,
    output logic        m_data_tlast,
    input  logic        m_data_tready,
    output logic [15:0] frame_count,
    output logic [15:0] error_count,
    output logic [15:0] overflow_count,
    output logic [2:0]  dbg_state
);
    localparam int CW = $clog2(MAX_PAYLOAD + 1) + 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   pay_q, pay_d;
    logic [15:0]     frame_q, frame_d, err_q, err_d, ovf_q, ovf_d;
    logic            is_hdr, is_ftr, is_term, wr_en, commit, rollback;
    logic            full, full_cm, ovf_inc, frm_inc;
    logic [1:0]      err_n;

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
        logic [16:0] s;
        s = {1'b0, c} + {15'd0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign is_hdr  = s_data_tdata == HEADER_VALUE;
    assign is_ftr  = s_data_tdata == FOOTER_VALUE;
    assign is_term = (s_data_tdata == TLAST_VALUE) && s_data_tlast;

    always_comb begin
        state_d  = state_q;
        pay_d    = pay_q;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        frm_inc  = 1'b0;
        ovf_inc  = 1'b0;
        err_n    = 2'd0;
        if (s_data_tvalid) begin
            // tlast on anything but the terminator is flagged, then parsed normally.
            if (s_data_tlast && !(s_data_tdata == TLAST_VALUE)) err_n = 2'd1;
            case (state_q)
                ST_IDLE: begin
                    if (is_hdr) begin
                        wr_en   = 1'b1;
                        state_d = ST_TSTAMP;
                    end else if (!is_term) begin
                        err_n = err_n + 2'd1;
                    end
                end
                ST_TSTAMP: begin
                    wr_en   = 1'b1;
                    pay_d   = '0;
                    state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (is_ftr) begin
                        wr_en   = 1'b1;
                        commit  = 1'b1;
                        frm_inc = 1'b1;
                        state_d = ST_POST_FOOTER;
                    end else if (is_hdr) begin
                        rollback = 1'b1;
                        wr_en    = 1'b1;
                        err_n    = err_n + 2'd1;
                        state_d  = ST_TSTAMP;
                    end else if (pay_q == CW'(MAX_PAYLOAD)) begin
                        rollback = 1'b1;
                        err_n    = err_n + 2'd1;
                        state_d  = ST_DROP;
                    end else begin
                        wr_en = 1'b1;
                        pay_d = pay_q + CW'(1);
                    end
                end
                ST_POST_FOOTER: begin
                    if (is_hdr) begin
                        wr_en   = 1'b1;
                        state_d = ST_TSTAMP;
                    end else begin
                        if (!is_term) err_n = err_n + 2'd1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (is_hdr) begin
                        wr_en   = 1'b1;
                        state_d = ST_TSTAMP;
                    end else if (is_ftr || is_term) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Any write into a full buffer abandons the frame in progress.
            if (wr_en && (rollback ? full_cm : full)) begin
                wr_en    = 1'b0;
                commit   = 1'b0;
                frm_inc  = 1'b0;
                rollback = 1'b1;
                ovf_inc  = 1'b1;
                state_d  = ST_DROP;
            end
        end
        frame_d = sat_add(frame_q, {1'b0, frm_inc});
        err_d   = sat_add(err_q, err_n);
        ovf_d   = sat_add(ovf_q, {1'b0, ovf_inc});
    end

    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            pay_q   <= '0;
            frame_q <= '0;
            err_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            pay_q   <= pay_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s_data_tready  = resetn;
    assign frame_count    = frame_q;
    assign error_count    = err_q;
    assign overflow_count = ovf_q;
    assign dbg_state      = state_q;

    frame_commit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (master_clock),
        .rst_n    (resetn),
        .wr_en    (wr_en),
        .wr_data  (s_data_tdata),
        .wr_last  (commit),
        .commit   (commit),
        .rollback (rollback),
        .full     (full),
        .full_cm  (full_cm),
        .m_tdata  (m_data_tdata),
        .m_tvalid (m_data_tvalid),
        .m_tlast  (m_data_tlast),
        .m_tready (m_data_tready)
    );

endmodule

// File: doc/packet_stream_checker.md
PACKET_STREAM_CHECKER -- requirements
Module: packet_stream_checker

Interface
REQ-001 The block SHALL take parameter FIFO_DEPTH, default 2048, power of two ≥16: frame buffer depth in 32-bit words.
REQ-002 The block SHALL take parameter MAX_PAYLOAD, default 1024: maximum number of payload words between timestamp and footer.
REQ-003 The block SHALL have master_clock, input, 1 bit: the single clock, 40 MHz.
REQ-004 The block SHALL have resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have s_data_tdata/tvalid/tlast, input, 32/1/1 bits: AXIS slave from the acquisition stage.
REQ-006 The block SHALL have s_data_tready, output, 1 bit: 1 whenever out of reset; the upstream stage ignores backpressure.
REQ-007 The block SHALL have m_data_tdata/tvalid/tlast, output, 32/1/1 bits, and m_data_tready, input, 1 bit: AXIS master toward the DMA.
REQ-008 The block SHALL have frame_count, error_count and overflow_count, outputs, 16 bits each: saturating status counters.
REQ-009 The block SHALL have dbg_state, output, 3 bits: the current FSM state.

Function
REQ-010 Framing words SHALL be: header 0xAAAAAAAA; timestamp (any value); payload; footer 0x55555555; optional terminator 0xBBBBBBBB with tlast=1.
REQ-011 An input word SHALL be accepted only on a cycle with s_data_tvalid=1.
REQ-012 The FSM states SHALL be IDLE, TSTAMP, PAYLOAD, POST_FOOTER and DROP.
REQ-013 In IDLE: header → write header word, go to TSTAMP; terminator with tlast → stay in IDLE, no error; any other word → discard it and increment error_count.
REQ-014 In TSTAMP: any word → write it, go to PAYLOAD, clear the payload counter.
REQ-015 In PAYLOAD: footer → write footer, commit the frame, increment frame_count, go to POST_FOOTER.
REQ-016 In PAYLOAD: header → roll back the partial frame, increment error_count, write the new header, go to TSTAMP.
REQ-017 In PAYLOAD: any other word → write it and increment the payload counter.
REQ-018 In PAYLOAD: a write that would make the payload counter exceed MAX_PAYLOAD → roll back, increment error_count, go to DROP.
REQ-019 The first 0x55555555 seen in PAYLOAD SHALL always end the frame.
REQ-020 In POST_FOOTER: header → write it, go to TSTAMP; terminator with tlast → go to IDLE, nothing is written.
REQ-021 In POST_FOOTER: any other word → increment error_count, go to IDLE.
REQ-022 In DROP: discard all words until a footer or terminator, then go to IDLE; a header in DROP → go to TSTAMP after writing the header.
REQ-023 s_data_tlast=1 on any word other than the terminator SHALL increment error_count; the word is then processed normally.
REQ-024 Buffer: a circular RAM with three pointers. The write pointer is speculative. The commit pointer captures write pointer +1 on a footer write. The read pointer is the output side.
REQ-025 Rollback SHALL set the write pointer to the commit pointer in the same cycle.
REQ-026 All pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping modulo 2×FIFO_DEPTH.
REQ-027 Full is when write − read = FIFO_DEPTH. A write attempted while full → roll back, increment overflow_count, go to DROP.
REQ-028 The output side SHALL present only committed words.
REQ-029 m_data_tvalid SHALL assert no earlier than 2 cycles after the footer is accepted.
REQ-030 m_data_tlast SHALL equal 1 exactly on the footer word of each frame.
REQ-031 While m_data_tvalid=1 and m_data_tready=0, m_data_tdata and m_data_tlast SHALL be held stable.
REQ-032 The output SHALL sustain 1 word/cycle when m_data_tready=1.
REQ-033 A simultaneous commit and read in the same cycle SHALL both take effect.
REQ-034 A rollback SHALL never move the write pointer behind the read pointer.
REQ-035 All counters SHALL saturate at 0xFFFF and never wrap.

Reset
REQ-036 On resetn=0, at any time, the FSM SHALL go to IDLE, all pointers to 0 and all counters to 0; m_data_tvalid, m_data_tlast, m_data_tdata and s_data_tready SHALL go to 0.
REQ-037 A reset during a frame SHALL discard both committed and uncommitted words.
REQ-038 The first word accepted after reset release SHALL be treated as in IDLE.

Structure
REQ-039 A shared package SHALL hold HEADER_VALUE, FOOTER_VALUE and TLAST_VALUE, the FSM state encoding, and the clog2-based pointer width function.
REQ-040 The buffer SHALL be one sub-module, frame_commit_fifo: RAM, three pointers, commit/rollback inputs, and a registered AXIS read port.
REQ-041 The FSM and counters SHALL live in the top level.

Verification
REQ-042 One frame (AAAAAAAA, 0x00001234, 3 payload words, 55555555, BBBBBBBB+tlast), m_data_tready=1 → 6 words out, tlast on 55555555, frame_count=1, error_count=0.
REQ-043 A header, timestamp and 2 payload words, then a new header and a full 1-payload frame → only the second frame (4 words) is output, error_count=1.
REQ-044 A frame with MAX_PAYLOAD+1 payload words → nothing is output, error_count=1; the next valid frame is output intact.
REQ-045 FIFO_DEPTH=16, m_data_tready=0, a 20-word frame → overflow_count=1, no output; then release tready and send a 5-word frame → exactly those 5 words are output.
REQ-046 Random m_data_tready toggling (50%) across 8 back-to-back frames → output equals input minus terminators, data stable under stall, frame_count=8.
REQ-047 resetn pulsed low mid-payload with a committed frame pending → m_data_tvalid=0 and counters=0 immediately; the next full frame is output correctly.
